// File: rtl/assoc_mem_pkg.sv
// Shared opcode and FSM state definitions for the associative memory.
package assoc_mem_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/assoc_mem_if.sv
// Request/result bundle. Handshake: a request transfers on a posedge where op_valid && op_ready;
// the requester holds op_* stable while op_ready is low. res_valid is a one-cycle pulse.
interface assoc_mem_if #(parameter int KW = 3, parameter int VW = 3, parameter int N = 4);
  localparam int IW = $clog2(N);

  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op_code;
  logic [KW-1:0] op_key;
  logic [VW-1:0] op_value;
  logic          res_valid;
  logic          res_hit;
  logic [VW-1:0] res_value;
  logic [IW-1:0] res_index;

  modport master (
    output op_valid, op_code, op_key, op_value,
    input  op_ready, res_valid, res_hit, res_value, res_index
  );

  modport slave (
    input  op_valid, op_code, op_key, op_value,
    output op_ready, res_valid, res_hit, res_value, res_index
  );
endinterface

// File: rtl/assoc_match.sv
// Parallel key comparators gated by valid bits, with a lowest-index priority encoder.
module assoc_match #(
  parameter int KW = 3,
  parameter int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [KW-1:0]        key,
  input  logic [N-1:0][KW-1:0] keys,
  input  logic [N-1:0]         valid,
  output logic [N-1:0]         match,
  output logic                 any_hit,
  output logic [IW-1:0]        hit_index
);

  for (genvar i = 0; i < N; i++) begin : g_cmp
    assign match[i] = valid[i] && (keys[i] == key);
  end

  assign any_hit = |match;

  always_comb begin
    hit_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (match[i]) hit_index = IW'(i);
    end
  end

endmodule

// File: rtl/assoc_mem.sv
// Writable key->value table with valid bits, round-robin eviction when full,
// and a multi-cycle CLEAR sweep that invalidates one entry per cycle.
module assoc_mem
  import assoc_mem_pkg::*;
#(
  parameter int KW = 3,
  parameter int VW = 3,
  parameter int N  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  assoc_mem_if.slave             bus,
  output logic                   full,
  output logic [$clog2(N+1)-1:0] count,
  output state_t                 dbg_state
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0][KW-1:0] keys_q;
  logic [VW-1:0]        vals_q [N];
  logic [N-1:0]         valid_q, valid_d;
  logic [IW-1:0]        victim_q, victim_d, clr_idx_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, ready_q;
  state_t               state_q;
  logic                 res_valid_q, res_hit_q;
  logic [VW-1:0]        res_value_q, res_val_d;
  logic [IW-1:0]        res_index_q, res_idx_d;
  logic [N-1:0]         match;
  logic                 any_hit;
  logic [IW-1:0]        hit_idx, free_idx, wr_idx;
  logic                 wr_en, accept;
  op_t                  op;

  function automatic logic [IW-1:0] lowest_free(input logic [N-1:0] v);
    lowest_free = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!v[i]) lowest_free = IW'(i);
    end
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    popcount = '0;
    for (int i = 0; i < N; i++) popcount = popcount + CW'(v[i]);
  endfunction

  assoc_match #(.KW(KW), .N(N)) u_match (
    .key       (bus.op_key),
    .keys      (keys_q),
    .valid     (valid_q),
    .match     (match),
    .any_hit   (any_hit),
    .hit_index (hit_idx)
  );

  assign accept   = bus.op_valid && ready_q;
  assign op       = op_t'(bus.op_code);
  assign free_idx = lowest_free(valid_q);

  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = hit_idx;
    res_idx_d = '0;
    res_val_d = '0;
    valid_d   = valid_q;
    victim_d  = victim_q;
    if (state_q == S_CLEAR) begin
      valid_d[clr_idx_q] = 1'b0;
      if (clr_idx_q == IW'(N - 1)) victim_d = '0;
    end else if (accept) begin
      case (op)
        OP_LOOKUP: begin
          if (any_hit) begin
            res_idx_d = hit_idx;
            res_val_d = vals_q[hit_idx];
          end
        end
        OP_INSERT: begin
          wr_en = 1'b1;
          if (any_hit) begin
            wr_idx = hit_idx;
          end else if (!full_q) begin
            wr_idx = free_idx;
          end else begin
            wr_idx   = victim_q;
            victim_d = victim_q + IW'(1);
          end
          res_idx_d       = wr_idx;
          res_val_d       = (any_hit || full_q) ? vals_q[wr_idx] : '0;
          valid_d[wr_idx] = 1'b1;
        end
        OP_DELETE: begin
          // Drops every matching copy so a duplicated key cannot linger.
          if (any_hit) begin
            valid_d   = valid_q & ~match;
            res_idx_d = hit_idx;
            res_val_d = vals_q[hit_idx];
          end
        end
        default: ;
      endcase
    end
    count_d = popcount(valid_d);
  end

  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      keys_q[wr_idx] <= bus.op_key;
      vals_q[wr_idx] <= bus.op_value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      valid_q     <= '0;
      victim_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      clr_idx_q   <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_value_q <= '0;
      res_index_q <= '0;
    end else begin
      valid_q     <= valid_d;
      victim_q    <= victim_d;
      count_q     <= count_d;
      full_q      <= (count_d == CW'(N));
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_value_q <= '0;
      res_index_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_CLEAR) begin
              state_q   <= S_CLEAR;
              ready_q   <= 1'b0;
              clr_idx_q <= '0;
            end else begin
              res_valid_q <= 1'b1;
              res_hit_q   <= any_hit;
              res_value_q <= res_val_d;
              res_index_q <= res_idx_d;
            end
          end
        end
        S_CLEAR: begin
          clr_idx_q <= clr_idx_q + IW'(1);
          if (clr_idx_q == IW'(N - 1)) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.op_ready  = ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.res_value = res_value_q;
  assign bus.res_index = res_index_q;
  assign full          = full_q;
  assign count         = count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_assoc_mem.sv
// Bench for assoc_mem: directed scenarios plus random traffic against a table model,
// on a 4-entry instance and an 8-entry wide-key instance.
module tb_assoc_mem;
  import assoc_mem_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  assoc_mem_if #(.KW(3), .VW(3), .N(4)) ifa ();
  assoc_mem_if #(.KW(5), .VW(8), .N(8)) ifb ();

  logic       full_a, full_b;
  logic [2:0] count_a;
  logic [3:0] count_b;
  state_t     st_a, st_b;

  assoc_mem #(.KW(3), .VW(3), .N(4)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa), .full(full_a), .count(count_a), .dbg_state(st_a)
  );
  assoc_mem #(.KW(5), .VW(8), .N(8)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb), .full(full_b), .count(count_b), .dbg_state(st_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference table: entries hold key/value/valid, plus the round-robin victim pointer.
  int cur_n;
  int mk [8];
  int mv [8];
  bit mvalid [8];
  int mvict;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int n);
    cur_n = n;
    mvict = 0;
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < cur_n; i++) if (mvalid[i]) c++;
    return c;
  endfunction

  task automatic model_op(input int op, input int key, input int val,
                          output int hit, output int rval, output int ridx);
    int m = -1;
    int f = -1;
    hit = 0; rval = 0; ridx = 0;
    for (int i = 0; i < cur_n; i++) if (m < 0 && mvalid[i] && mk[i] == key) m = i;
    for (int i = 0; i < cur_n; i++) if (f < 0 && !mvalid[i]) f = i;
    if (op == 0) begin
      if (m >= 0) begin hit = 1; rval = mv[m]; ridx = m; end
    end else if (op == 1) begin
      if (m >= 0) begin
        hit = 1; rval = mv[m]; ridx = m; mv[m] = val;
      end else if (f >= 0) begin
        ridx = f; mk[f] = key; mv[f] = val; mvalid[f] = 1'b1;
      end else begin
        ridx = mvict; rval = mv[mvict]; mk[mvict] = key; mv[mvict] = val;
        mvict = (mvict + 1) % cur_n;
      end
    end else if (op == 2) begin
      if (m >= 0) begin hit = 1; rval = mv[m]; ridx = m; mvalid[m] = 1'b0; end
    end
  endtask

  task automatic a_op(input int op, input int key, input int val);
    int h, rv, ri;
    chk("a_ready_before", 32'(ifa.op_ready), 1);
    model_op(op, key, val, h, rv, ri);
    ifa.op_valid = 1'b1;
    ifa.op_code  = 2'(op);
    ifa.op_key   = 3'(key);
    ifa.op_value = 3'(val);
    @(posedge clock); #1;
    ifa.op_valid = 1'b0;
    chk("a_res_valid", 32'(ifa.res_valid), 1);
    chk("a_res_hit", 32'(ifa.res_hit), 32'(h));
    chk("a_res_value", 32'(ifa.res_value), 32'(rv));
    chk("a_res_index", 32'(ifa.res_index), 32'(ri));
    chk("a_count", 32'(count_a), 32'(model_count()));
    chk("a_full", 32'(full_a), 32'(model_count() == 4));
  endtask

  task automatic b_op(input int op, input int key, input int val);
    int h, rv, ri;
    model_op(op, key, val, h, rv, ri);
    ifb.op_valid = 1'b1;
    ifb.op_code  = 2'(op);
    ifb.op_key   = 5'(key);
    ifb.op_value = 8'(val);
    @(posedge clock); #1;
    ifb.op_valid = 1'b0;
    chk("b_res_valid", 32'(ifb.res_valid), 1);
    chk("b_res_hit", 32'(ifb.res_hit), 32'(h));
    chk("b_res_value", 32'(ifb.res_value), 32'(rv));
    chk("b_res_index", 32'(ifb.res_index), 32'(ri));
    chk("b_count", 32'(count_b), 32'(model_count()));
    chk("b_full", 32'(full_b), 32'(model_count() == 8));
  endtask

  // CLEAR followed by a LOOKUP held on the bus while op_ready is low.
  task automatic a_clear(input int lkey);
    int h, rv, ri;
    chk("clr_ready_before", 32'(ifa.op_ready), 1);
    ifa.op_valid = 1'b1;
    ifa.op_code  = 2'(3);
    ifa.op_key   = 3'(lkey);
    @(posedge clock); #1;
    ifa.op_code = 2'(0);
    chk("clr_ready_low", 32'(ifa.op_ready), 0);
    chk("clr_state", 32'(st_a), 32'(S_CLEAR));
    chk("clr_count_start", 32'(count_a), 32'(model_count()));
    chk("clr_no_early_res", 32'(ifa.res_valid), 0);
    for (int c = 0; c < 4; c++) begin
      mvalid[c] = 1'b0;
      if (c == 3) mvict = 0;
      @(posedge clock); #1;
      chk("clr_count_step", 32'(count_a), 32'(model_count()));
      chk("clr_ready_step", 32'(ifa.op_ready), 32'(c == 3));
      chk("clr_res_valid_step", 32'(ifa.res_valid), 32'(c == 3));
      chk("clr_state_step", 32'(st_a), 32'((c == 3) ? S_IDLE : S_CLEAR));
    end
    chk("clr_res_hit", 32'(ifa.res_hit), 0);
    chk("clr_res_index", 32'(ifa.res_index), 0);
    chk("clr_res_value", 32'(ifa.res_value), 0);
    model_op(0, lkey, 0, h, rv, ri);
    @(posedge clock); #1;
    ifa.op_valid = 1'b0;
    chk("clr_held_valid", 32'(ifa.res_valid), 1);
    chk("clr_held_hit", 32'(ifa.res_hit), 32'(h));
    chk("clr_held_value", 32'(ifa.res_value), 32'(rv));
  endtask

  initial begin
    reset = 1'b1;
    ifa.op_valid = 1'b0; ifa.op_code = '0; ifa.op_key = '0; ifa.op_value = '0;
    ifb.op_valid = 1'b0; ifb.op_code = '0; ifb.op_key = '0; ifb.op_value = '0;
    model_reset(4);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    chk("rst_res_valid", 32'(ifa.res_valid), 0);
    chk("rst_ready", 32'(ifa.op_ready), 1);
    chk("rst_count", 32'(count_a), 0);
    chk("rst_full", 32'(full_a), 0);
    chk("rst_res_hit", 32'(ifa.res_hit), 0);
    chk("rst_res_value", 32'(ifa.res_value), 0);
    chk("rst_res_index", 32'(ifa.res_index), 0);
    chk("rst_state", 32'(st_a), 32'(S_IDLE));
    chk("rst_count_b", 32'(count_b), 0);

    // Directed table walk: fill, evict, update, delete, reallocate.
    a_op(0, 5, 0);
    a_op(1, 5, 1); a_op(1, 6, 2); a_op(1, 1, 1); a_op(1, 2, 3);
    chk("dir_full_after_fill", 32'(full_a), 1);
    a_op(0, 6, 0); a_op(0, 7, 0);
    a_op(1, 7, 4);
    chk("dir_evict0_index", 32'(ifa.res_index), 0);
    chk("dir_evict0_value", 32'(ifa.res_value), 1);
    a_op(1, 3, 5); a_op(0, 5, 0);
    a_op(1, 6, 6);
    chk("dir_evict2_index", 32'(ifa.res_index), 2);
    a_op(1, 2, 7);
    chk("dir_update_hit", 32'(ifa.res_hit), 1);
    chk("dir_update_old", 32'(ifa.res_value), 3);
    a_op(2, 2, 0);
    chk("dir_delete_count", 32'(count_a), 3);
    a_op(1, 4, 4);
    chk("dir_realloc_index", 32'(ifa.res_index), 3);
    a_op(1, 0, 5);
    chk("dir_victim_kept", 32'(ifa.res_index), 3);

    a_clear(7);

    // Reset lands in the second sweep cycle.
    a_op(1, 1, 1); a_op(1, 2, 2); a_op(1, 3, 3);
    ifa.op_valid = 1'b1; ifa.op_code = 2'(3);
    @(posedge clock); #1;
    ifa.op_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset(4);
    chk("rclr_count", 32'(count_a), 0);
    chk("rclr_ready", 32'(ifa.op_ready), 1);
    chk("rclr_res_valid", 32'(ifa.res_valid), 0);
    chk("rclr_state", 32'(st_a), 32'(S_IDLE));
    a_op(0, 1, 0);

    // Random traffic on the small table.
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 39);
      if (r == 0) a_clear($urandom_range(0, 7));
      else a_op(r % 3, $urandom_range(0, 7), $urandom_range(0, 7));
    end

    // Wide instance: fill, then 17 evictions to see the pointer wrap.
    model_reset(8);
    for (int k = 0; k < 8; k++) b_op(1, k, k + 10);
    b_op(1, 8, 100);
    chk("b_first_evict_index", 32'(ifb.res_index), 0);
    chk("b_first_evict_value", 32'(ifb.res_value), 10);
    for (int k = 9; k < 24; k++) b_op(1, k, k + 100);
    chk("b_16th_evict_index", 32'(ifb.res_index), 7);
    b_op(1, 24, 200);
    chk("b_wrap_index", 32'(ifb.res_index), 0);
    for (int i = 0; i < 150; i++) begin
      b_op($urandom_range(0, 2), $urandom_range(0, 31), $urandom_range(0, 255));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
